ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

PS/2 keyboard receive front-end for the i8088 peripheral side, clocked from the 83 MHz bus clock. It sits between the raw `ps2_clk`/`ps2_data` board pins and the CPU-facing keyboard port register in `i8088_cpu`. It synchronises and filters the PS/2 lines, deframes 11-bit device-to-host frames, checks them, and buffers good scancodes in a small FIFO. It raises a level interrupt request while data is pending.

## Interface
Parameters:
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW entries (8).
- `FILT_LEN`, 8: consecutive equal samples required before the filtered `ps2_clk` changes.
- `TIMEOUT_CYC`, 16600: idle cycles (≈200 µs at 83 MHz) after which a partial frame is discarded.

Ports:
- `AXI_CLK`  in  1: 83 MHz bus clock; the single clock of the block.
- `RESETN`  in  1: asynchronous, active-low reset.
- `ps2_clk`  in  1: raw PS/2 clock pin, asynchronous.
- `ps2_data`  in  1: raw PS/2 data pin, asynchronous.
- `rd_pop`  in  1: single-cycle pulse that consumes the head byte.
- `ovf_clr`  in  1: clears the sticky `overflow` flag.
- `rd_data`  out  8: FIFO head byte; valid when `rd_valid`=1.
- `rd_valid`  out  1: FIFO non-empty.
- `fifo_count`  out  FIFO_AW+1: number of occupied entries.
- `INTR_kbd`  out  1: level interrupt, equal to `rd_valid`.
- `err_parity`  out  1: one-cycle pulse on an odd-parity failure.
- `err_frame`  out  1: one-cycle pulse on a bad start/stop bit or a timeout.
- `overflow`  out  1: sticky flag, set when a good byte is dropped because the FIFO is full.

## Operation
- Input conditioning:
  - 2-flop synchroniser on each pin.
  - `ps2_clk` then passes through a FILT_LEN-sample glitch filter; the filtered clock resets high.
  - Sampling strobe = filtered falling edge. `ps2_data` is sampled on that strobe, taken from the synchronised stage.
- Frame FSM states: IDLE, SHIFT, CHECK.
  - IDLE: strobe with data=0 → SHIFT, bit_cnt=0. Strobe with data=1 → stay in IDLE and pulse `err_frame`.
  - SHIFT: each strobe shifts data in LSB-first into a 10-bit register (8 data bits, parity, stop) and increments bit_cnt. When bit_cnt reaches 10 → CHECK.
  - CHECK (one cycle), then → IDLE:
    - stop≠1 → `err_frame`.
    - XOR of the 8 data bits and the parity bit ≠1 → `err_parity`.
    - Both faults → both pulses in the same cycle.
    - Otherwise the byte is pushed to the FIFO.
- FIFO: circular, with FIFO_AW-bit pointers plus a count.
  - Push when full → byte dropped, `overflow`←1, count unchanged.
  - `rd_pop` when empty → ignored, no pointer change.
  - Simultaneous push and pop → both take effect, count unchanged. This also applies when the FIFO is full: the pop frees the slot, the push is accepted, and `overflow` is not set.
  - Pointer wrap is natural modulo 2**FIFO_AW.
- `overflow` clears on `ovf_clr`. If set and clear coincide, set wins.
- Reset mid-frame: the FSM goes to IDLE and the shift register, bit_cnt, FIFO pointers, count and flags clear. A partial frame in progress is lost.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `fifo_count`=0, `INTR_kbd`=0, `err_parity`=0, `err_frame`=0, `overflow`=0.
- Pin-to-strobe latency: 2 synchroniser cycles + FILT_LEN filter cycles + 1 edge-detect cycle = 11 cycles at defaults.
- Stop-bit strobe → CHECK: 1 cycle. Byte pushed at the end of CHECK. `rd_valid`/`INTR_kbd` rise 2 cycles after the stop-bit strobe.
- `rd_data` is a registered read of the head entry. It updates in the cycle after a pop, or after a push into an empty FIFO, i.e. together with `rd_valid`.
- `rd_pop` is sampled on the rising edge of `AXI_CLK`. `fifo_count` updates on the same edge.

## Configuration
- Macro: `PS2_RX_TIMEOUT_EN`.
- Defined:
  - A counter runs in SHIFT and is cleared on every strobe.
  - When the counter reaches TIMEOUT_CYC → pulse `err_frame`, return to IDLE, discard the partial frame.
- Undefined:
  - No counter is built; SHIFT waits indefinitely for further strobes.
  - `err_frame` is driven only by start/stop faults.

## Test plan
- Good frame for 0x1C (start 0, data LSB-first, parity 0, stop 1) → 2 cycles after the stop strobe: `rd_valid`=1, `rd_data`=0x1C, `fifo_count`=1, `INTR_kbd`=1. Then `rd_pop` → `rd_valid`=0 next cycle.
- Frame 0x1C with parity bit 1 → one-cycle `err_parity`, `fifo_count` stays 0. Frame with stop=0 → one-cycle `err_frame`, no push.
- 9 good frames 0x01..0x09 with no pops → `fifo_count`=8, `overflow`=1, head=0x01. Eight pops return 0x01..0x08 in order. Then `ovf_clr` → `overflow`=0.
- FIFO full, and `rd_pop` asserted in the same cycle as the CHECK push of 0x55 → `fifo_count` stays 8, `overflow` stays 0, 0x55 is last out.
- 3-cycle low glitch on `ps2_clk` → no strobe, FSM stays in IDLE, no error pulses.
- With `PS2_RX_TIMEOUT_EN`: 4 bits sent, then the clock is held high for 16600 cycles → `err_frame` pulse, FSM back in IDLE. A following good frame 0xAA is received correctly. Separately, assert RESETN low mid-frame → all outputs at their reset values immediately.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync, clock glitch filter, 11-bit deframer, 8-entry FIFO.
// Ports: AXI_CLK/RESETN, ps2_clk/ps2_data pins, rd_pop/ovf_clr in; rd_data/rd_valid/
// fifo_count/INTR_kbd out; err_parity/err_frame pulses, sticky overflow.
// Optional macro PS2_RX_TIMEOUT_EN: discard partial frames after TIMEOUT_CYC idle cycles.
module ps2_kbd_rx #(
  parameter int FIFO_AW     = 3,
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 16600
) (
  input  logic               AXI_CLK,
  input  logic               RESETN,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               rd_pop,
  input  logic               ovf_clr,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               INTR_kbd,
  output logic               err_parity,
  output logic               err_frame,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int FW    = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} st_t;

  st_t               st, nxt;
  logic [1:0]        clk_sy, dat_sy;
  logic [FW-1:0]     filt_cnt;
  logic              filt_clk, filt_d;
  logic              strobe, bit_in;
  logic [9:0]        sh;
  logic [3:0]        bit_cnt;
  logic              to_hit;
  logic              push, push_ok, pop_ok;
  logic [7:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) begin
      clk_sy <= 2'b11;
      dat_sy <= 2'b11;
    end else begin
      clk_sy <= {clk_sy[0], ps2_clk};
      dat_sy <= {dat_sy[0], ps2_data};
    end
  end

  // Filtered clock flips only after FILT_LEN consecutive differing samples.
  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) begin
      filt_cnt <= '0;
      filt_clk <= 1'b1;
      filt_d   <= 1'b1;
    end else begin
      filt_d <= filt_clk;
      if (clk_sy[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= clk_sy[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign strobe = filt_d & ~filt_clk;
  assign bit_in = dat_sy[1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN)                    to_cnt <= '0;
    else if (st != SHIFT || strobe) to_cnt <= '0;
    else                            to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (st == SHIFT) && !strobe
               && (to_cnt == TW'(TIMEOUT_CYC));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) st <= IDLE;
    else         st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:  if (strobe && !bit_in) nxt = SHIFT;
      SHIFT: if (strobe && bit_cnt == 4'd9) nxt = CHECK;
             else if (to_hit)               nxt = IDLE;
      CHECK: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // sh[7:0] data, sh[8] parity, sh[9] stop once ten bits are in.
  always_comb begin
    err_frame  = 1'b0;
    err_parity = 1'b0;
    push       = 1'b0;
    unique case (st)
      IDLE:  err_frame = strobe & bit_in;
      SHIFT: err_frame = to_hit;
      CHECK: begin
        err_frame  = ~sh[9];
        err_parity = ~(^sh[8:0]);
        push       = sh[9] & (^sh[8:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (st == IDLE && strobe && !bit_in) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (st == SHIFT && strobe) begin
      sh      <= {bit_in, sh[9:1]};
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop_ok  = rd_pop && (fifo_count != '0);
  assign push_ok = push
                && (fifo_count != (FIFO_AW+1)'(DEPTH) || pop_ok);

  always_ff @(posedge AXI_CLK) begin
    if (push_ok) mem[wr_ptr] <= sh[7:0];
  end

  always_ff @(posedge AXI_CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rd_data    <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (pop_ok) begin
        if (fifo_count == (FIFO_AW+1)'(1) && push_ok) rd_data <= sh[7:0];
        else rd_data <= mem[rd_ptr + 1'b1];
      end else if (push_ok && fifo_count == '0) begin
        rd_data <= sh[7:0];
      end
      if (push && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)     overflow <= 1'b0;
    end
  end

  assign rd_valid = (fifo_count != '0);
  assign INTR_kbd = rd_valid;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Randomized bench for ps2_kbd_rx against a queue-based reference model.
// Drives PS/2 frames on the pins and checks FIFO, flags and error pulses.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8;
  localparam int TO    = 16600;

  logic       AXI_CLK = 1'b0;
  logic       RESETN  = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_pop  = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       INTR_kbd, err_parity, err_frame, overflow;

  always #6 AXI_CLK = ~AXI_CLK;

  ps2_kbd_rx dut (
    .AXI_CLK(AXI_CLK), .RESETN(RESETN),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_pop(rd_pop), .ovf_clr(ovf_clr),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .INTR_kbd(INTR_kbd),
    .err_parity(err_parity), .err_frame(err_frame),
    .overflow(overflow)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_perr = 0;
  int n_ferr = 0;
  logic [7:0] q[$];
  bit m_ovf = 1'b0;

  always @(posedge AXI_CLK) begin
    if (err_parity) n_perr++;
    if (err_frame)  n_ferr++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge AXI_CLK);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(12);
    ps2_clk = 1'b0;
    tick(30);
    ps2_clk = 1'b1;
    tick(12);
  endtask

  task automatic check_state(input int ef, input int ep);
    chk("err_frame_cnt", n_ferr, ef);
    chk("err_parity_cnt", n_perr, ep);
    chk("fifo_count", fifo_count, q.size());
    chk("rd_valid", rd_valid, q.size() != 0);
    chk("intr", INTR_kbd, q.size() != 0);
    chk("overflow", overflow, m_ovf);
    if (q.size() != 0) chk("head", rd_data, q[0]);
  endtask

  // mode 0: plain; 1: pop in the CHECK cycle; 2: check rd_valid latency
  task automatic send_frame(input logic [7:0] b, input bit pflip,
                            input bit stop, input int mode);
    logic [10:0] f;
    f = {stop, (~^b) ^ pflip, b, 1'b0};
    n_perr = 0;
    n_ferr = 0;
    for (int i = 0; i < 10; i++) send_bit(f[i]);
    ps2_data = f[10];
    tick(12);
    ps2_clk = 1'b0;
    if (mode == 1) begin
      tick(11);
      rd_pop = 1'b1;
      tick(1);
      rd_pop = 1'b0;
      tick(18);
    end else if (mode == 2) begin
      tick(11);
      chk("lat_pre", rd_valid, 0);
      tick(1);
      chk("lat_post", rd_valid, 1);
      chk("lat_data", rd_data, b);
      tick(18);
    end else begin
      tick(30);
    end
    ps2_clk = 1'b1;
    tick(20);
    if (mode == 1 && q.size() != 0) void'(q.pop_front());
    if (stop && !pflip) begin
      if (q.size() < DEPTH) q.push_back(b);
      else m_ovf = 1'b1;
    end
    check_state(stop ? 0 : 1, pflip ? 1 : 0);
  endtask

  task automatic do_pop();
    if (q.size() != 0) chk("pop_head", rd_data, q[0]);
    rd_pop = 1'b1;
    tick(1);
    rd_pop = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    chk("pop_count", fifo_count, q.size());
    chk("pop_valid", rd_valid, q.size() != 0);
    if (q.size() != 0) chk("pop_next", rd_data, q[0]);
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_intr", INTR_kbd, 0);
    chk("rst_err_parity", err_parity, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_overflow", overflow, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_reset_vals();
    RESETN = 1'b1;
    tick(5);

    send_frame(8'h1C, 1'b0, 1'b1, 2);
    do_pop();
    send_frame(8'h1C, 1'b1, 1'b1, 0);
    send_frame(8'h1C, 1'b0, 1'b0, 0);

    n_ferr = 0;
    n_perr = 0;
    send_bit(1'b1);
    tick(20);
    chk("bad_start_ferr", n_ferr, 1);
    chk("bad_start_perr", n_perr, 0);

    n_ferr = 0;
    ps2_clk = 1'b0;
    tick(3);
    ps2_clk = 1'b1;
    tick(30);
    chk("glitch_ferr", n_ferr, 0);
    chk("glitch_perr", n_perr, 0);
    send_frame(8'h3A, 1'b0, 1'b1, 0);
    do_pop();

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 0);
    chk("ovf_head", rd_data, 8'h01);
    for (int i = 0; i < 8; i++) do_pop();
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    m_ovf = 1'b0;
    chk("ovf_clr", overflow, 0);

    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 0);
    send_frame(8'h55, 1'b0, 1'b1, 1);
    for (int i = 0; i < 7; i++) do_pop();
    chk("last_55", rd_data, 8'h55);
    do_pop();

    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      bit pf, sp;
      int md, np;
      b  = 8'($urandom);
      pf = ($urandom_range(0, 4) == 0);
      sp = ($urandom_range(0, 6) != 0);
      md = ($urandom_range(0, 5) == 0) ? 1 : 0;
      send_frame(b, pf, sp, md);
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) do_pop();
    end

    send_frame(8'h42, 1'b0, 1'b1, 0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #3 RESETN = 1'b0;
    #1 check_reset_vals();
    q.delete();
    m_ovf = 1'b0;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    tick(2);
    RESETN = 1'b1;
    tick(5);
    send_frame(8'h99, 1'b0, 1'b1, 0);
    do_pop();

`ifdef PS2_RX_TIMEOUT_EN
    n_ferr = 0;
    n_perr = 0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    tick(TO + 100);
    chk("timeout_ferr", n_ferr, 1);
    chk("timeout_perr", n_perr, 0);
    send_frame(8'hAA, 1'b0, 1'b1, 0);
    do_pop();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
